// File: rtl/pwm_pkg.sv
// Shared types and reset defaults for the PWM configuration controller.
package pwm_pkg;

   localparam int WIDTH_DEF = 16;

   localparam int RST_UPPER = 500;
   localparam int RST_LOWER = 250;
   localparam int RST_STEP  = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PENDING = 2'd2
   } state_t;

endpackage

// File: rtl/pwm_cfg_check.sv
// Combinational legality check of a requested triangle configuration.
module pwm_cfg_check
   import pwm_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] upper,
   input  logic [WIDTH-1:0] lower,
   input  logic [WIDTH-1:0] step,
   output logic             valid
);

   logic [WIDTH-1:0] span;

   // span only matters when lower < upper, so the unsigned wrap is harmless
   assign span  = upper - lower;
   assign valid = (lower < upper) && (step != '0) && (step <= span);

endmodule

// File: rtl/pwm_cfg_ctrl.sv
// Accepts triangle-generator configurations from a host and applies them
// at the next waveform trough, or after a timeout if no trough arrives.
module pwm_cfg_ctrl
   import pwm_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic             MClk,
   input  logic             RstN,
   input  logic             CfgValid,
   output logic             CfgReady,
   input  logic [WIDTH-1:0] CfgUpper,
   input  logic [WIDTH-1:0] CfgLower,
   input  logic [WIDTH-1:0] CfgStep,
   input  logic             Stop,
   input  logic [WIDTH-1:0] TWave,
   output logic [WIDTH-1:0] UpperLimit,
   output logic [WIDTH-1:0] LowerLimit,
   output logic [WIDTH-1:0] TriangleStepSize,
   output logic             GenRstN,
   output logic             CfgApplied,
   output logic             CfgErr,
   output logic             ForcedApply
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] upper_nx, lower_nx, step_nx;
   logic [WIDTH-1:0] sh_upper, sh_lower, sh_step;
   logic [WIDTH-1:0] sh_upper_nx, sh_lower_nx, sh_step_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             applied_nx, err_nx, forced_nx, ready_nx;
   logic             cfg_ok, take, trough;

   pwm_cfg_check #(.WIDTH(WIDTH)) u_check (
      .upper (CfgUpper),
      .lower (CfgLower),
      .step  (CfgStep),
      .valid (cfg_ok)
   );

   assign take   = CfgValid && CfgReady;
   assign trough = TWave <= LowerLimit;

   always_comb begin
      state_nx    = state;
      upper_nx    = UpperLimit;
      lower_nx    = LowerLimit;
      step_nx     = TriangleStepSize;
      sh_upper_nx = sh_upper;
      sh_lower_nx = sh_lower;
      sh_step_nx  = sh_step;
      cnt_nx      = cnt;
      applied_nx  = 1'b0;
      err_nx      = CfgErr;
      forced_nx   = ForcedApply;

      if (Stop) begin
         // Stop wins over any offer; applied limits are intentionally kept
         state_nx    = ST_IDLE;
         sh_upper_nx = '0;
         sh_lower_nx = '0;
         sh_step_nx  = '0;
         cnt_nx      = '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (take) begin
                  if (cfg_ok) begin
                     upper_nx   = CfgUpper;
                     lower_nx   = CfgLower;
                     step_nx    = CfgStep;
                     applied_nx = 1'b1;
                     err_nx     = 1'b0;
                     state_nx   = ST_RUN;
                  end else begin
                     err_nx = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (take) begin
                  if (cfg_ok) begin
                     sh_upper_nx = CfgUpper;
                     sh_lower_nx = CfgLower;
                     sh_step_nx  = CfgStep;
                     cnt_nx      = '0;
                     err_nx      = 1'b0;
                     state_nx    = ST_PENDING;
                  end else begin
                     err_nx = 1'b1;
                  end
               end
            end
            ST_PENDING: begin
               if (trough || cnt == CNT_LAST) begin
                  // a trough on the timeout edge still counts as a clean apply
                  upper_nx   = sh_upper;
                  lower_nx   = sh_lower;
                  step_nx    = sh_step;
                  applied_nx = 1'b1;
                  forced_nx  = !trough;
                  cnt_nx     = '0;
                  state_nx   = ST_RUN;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end

      ready_nx = !Stop && (state_nx != ST_PENDING);
   end

   always_ff @(posedge MClk or negedge RstN) begin
      if (!RstN) begin
         state            <= ST_IDLE;
         UpperLimit       <= WIDTH'(RST_UPPER);
         LowerLimit       <= WIDTH'(RST_LOWER);
         TriangleStepSize <= WIDTH'(RST_STEP);
         sh_upper         <= '0;
         sh_lower         <= '0;
         sh_step          <= '0;
         cnt              <= '0;
         GenRstN          <= 1'b0;
         CfgReady         <= 1'b1;
         CfgApplied       <= 1'b0;
         CfgErr           <= 1'b0;
         ForcedApply      <= 1'b0;
      end else begin
         state            <= state_nx;
         UpperLimit       <= upper_nx;
         LowerLimit       <= lower_nx;
         TriangleStepSize <= step_nx;
         sh_upper         <= sh_upper_nx;
         sh_lower         <= sh_lower_nx;
         sh_step          <= sh_step_nx;
         cnt              <= cnt_nx;
         GenRstN          <= (state_nx != ST_IDLE);
         CfgReady         <= ready_nx;
         CfgApplied       <= applied_nx;
         CfgErr           <= err_nx;
         ForcedApply      <= forced_nx;
      end
   end

endmodule
